// File: rtl/spram_ctrl.sv
// spram_ctrl: turns a valid/ready request channel into single-port RAM read/write cycles.
// Optional macro SPRAM_CTRL_WRACK_EN: every write is acknowledged on the response channel.
module spram_ctrl #(
    parameter int Data_Width   = 8,
    parameter int RAM_Depth    = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wr,
    input  logic [$clog2(RAM_Depth)-1:0] req_addr,
    input  logic [Data_Width-1:0]        req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [Data_Width-1:0]        rsp_rdata,
    output logic                         mem_cs,
    output logic                         mem_oe,
    output logic                         mem_wr_en,
    output logic [$clog2(RAM_Depth)-1:0] mem_addr,
    inout  wire  [Data_Width-1:0]        mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                state, state_nx;
    logic [2:0]            cnt;
    logic [Data_Width-1:0] wdata_q;
    logic                  drive;
    logic                  accept;
    logic                  ready_nx, valid_nx, cs_nx, oe_nx, we_nx, drive_nx;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign mem_data = drive ? wdata_q : 'z;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = req_wr ? WRITE : READ;
`ifdef SPRAM_CTRL_WRACK_EN
            WRITE: state_nx = RESP;
`else
            WRITE: state_nx = IDLE;
`endif
            READ:  if (cnt == 3'(READ_LATENCY)) state_nx = RESP;
            RESP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ready_nx = (state_nx == IDLE);
        valid_nx = (state_nx == RESP);
        cs_nx    = (state_nx == WRITE) || (state_nx == READ);
        oe_nx    = (state_nx == READ);
        we_nx    = (state_nx == WRITE);
        drive_nx = (state_nx == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_cs    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            wdata_q   <= '0;
            drive     <= 1'b0;
        end else begin
            state     <= state_nx;
            req_ready <= ready_nx;
            rsp_valid <= valid_nx;
            mem_cs    <= cs_nx;
            mem_oe    <= oe_nx;
            mem_wr_en <= we_nx;
            drive     <= drive_nx;
            cnt       <= (state == READ && state_nx == READ) ? cnt + 3'd1 : '0;
            if (accept) begin
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == READ && state_nx == RESP)
                rsp_rdata <= mem_data;
`ifdef SPRAM_CTRL_WRACK_EN
            if (state == WRITE)
                rsp_rdata <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl: two controllers (READ_LATENCY 1 and 3) share one stimulus stream,
// each with its own SPRAM model and transaction-level reference model.
`timescale 1ns/1ps
module tb_spram_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid_a [2];
    logic          req_wr_a    [2];
    logic [AW-1:0] req_addr_a  [2];
    logic [DW-1:0] req_wdata_a [2];
    logic          rsp_ready_a [2];
    logic          rdy_a       [2];
    logic          rsp_valid_a [2];
    logic [DW-1:0] rdata_a     [2];
    logic          cs_a        [2];
    logic          oe_a        [2];
    logic          we_a        [2];
    logic [AW-1:0] addr_a      [2];
    wire  [DW-1:0] data_a      [2];

    logic [DW-1:0] got_a     [2];
    int            got_cnt_a [2] = '{0, 0};
    int            ack_cnt_a [2] = '{0, 0};
    int            rsp_mode = 0;  // 0: always ready, 1: random, 2: held low

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got 'h%0h, expected 'h%0h (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // A released bus floats; 2-state simulators show a floating net as zero.
    function automatic bit bus_free(input logic [DW-1:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        wire  [DW-1:0] mem_data;
        logic [DW-1:0] ram [DEPTH];
        int            ocnt = 0;
        logic          ram_drv;

        spram_ctrl #(.Data_Width(DW), .RAM_Depth(DEPTH), .READ_LATENCY(LAT)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid_a[g]),
            .req_ready (rdy_a[g]),
            .req_wr    (req_wr_a[g]),
            .req_addr  (req_addr_a[g]),
            .req_wdata (req_wdata_a[g]),
            .rsp_valid (rsp_valid_a[g]),
            .rsp_ready (rsp_ready_a[g]),
            .rsp_rdata (rdata_a[g]),
            .mem_cs    (cs_a[g]),
            .mem_oe    (oe_a[g]),
            .mem_wr_en (we_a[g]),
            .mem_addr  (addr_a[g]),
            .mem_data  (mem_data)
        );

        assign data_a[g] = mem_data;

        // SPRAM: data valid LAT edges after cs&oe rise, written at the closing edge of cs&wr_en.
        initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        always @(posedge clk) begin
            if (cs_a[g] && we_a[g]) ram[addr_a[g]] = mem_data;
            ocnt <= (cs_a[g] && oe_a[g]) ? ocnt + 1 : 0;
        end
        assign ram_drv  = cs_a[g] && oe_a[g] && (ocnt >= LAT);
        assign mem_data = ram_drv ? ram[addr_a[g]] : 'z;

        // Reference model: age counts edges since a request was accepted (-1 when idle).
        logic [DW-1:0] ref_mem [DEPTH];
        int            m_age = -1;
        bit            m_rdy = 0;
        bit            m_resp = 0;
        bit            m_wr = 0;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wdata = '0;
        logic [DW-1:0] m_rdata = '0;

        initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_age  = -1;
                m_rdy  = 0;
                m_resp = 0;
            end else begin
                if (m_resp) begin
                    if (rsp_ready_a[g]) begin
                        m_resp = 0;
                        m_age  = -1;
                    end
                end else if (m_age < 0) begin
                    if (m_rdy && req_valid_a[g]) begin
                        m_age   = 1;
                        m_wr    = req_wr_a[g];
                        m_addr  = req_addr_a[g];
                        m_wdata = req_wdata_a[g];
                        m_rdata = ref_mem[req_addr_a[g]];
                    end
                end else begin
                    m_age++;
                    if (m_wr && m_age == 2) begin
                        ref_mem[m_addr] = m_wdata;
`ifdef SPRAM_CTRL_WRACK_EN
                        m_resp  = 1;
                        m_rdata = '0;
`else
                        m_age   = -1;
`endif
                    end else if (!m_wr && m_age == LAT + 2) begin
                        m_resp = 1;
                    end
                end
                m_rdy = 1;
            end
        end

        always @(negedge clk) begin : cmp
            bit w, r, idle;
            w    = m_wr && m_age == 1 && !m_resp;
            r    = !m_wr && m_age >= 1 && m_age <= LAT + 1 && !m_resp;
            idle = m_age < 0;
            chk("req_ready", g, rdy_a[g], idle && m_rdy);
            chk("rsp_valid", g, rsp_valid_a[g], m_resp);
            if (m_resp) chk("rsp_rdata", g, rdata_a[g], m_rdata);
            chk("mem_cs", g, cs_a[g], w || r);
            chk("mem_oe", g, oe_a[g], r);
            chk("mem_wr_en", g, we_a[g], w);
            if (w || r) chk("mem_addr", g, addr_a[g], m_addr);
            if (w) chk("mem_data", g, mem_data, m_wdata);
            else if (!ram_drv) chk("bus_release", g, bus_free(mem_data), 1);

            rsp_ready_a[g] = (rsp_mode == 0) ? 1'b1 :
                             (rsp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rsp_valid_a[g] && rsp_ready_a[g]) begin
                if (m_wr) ack_cnt_a[g]++;
                else begin
                    got_a[g] = rdata_a[g];
                    got_cnt_a[g]++;
                end
            end
        end
    end

    // Present one request to both lanes; return at the negedge after both accepted it.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit pend [2];
        bit done [2];
        int t = 0;
        for (int l = 0; l < 2; l++) begin
            pend[l] = 0;
            done[l] = 0;
            req_valid_a[l] = 1'b1;
            req_wr_a[l]    = wr;
            req_addr_a[l]  = a;
            req_wdata_a[l] = d;
        end
        while (!(done[0] && done[1])) begin
            for (int l = 0; l < 2; l++) begin
                if (pend[l]) begin
                    req_valid_a[l] = 1'b0;
                    done[l] = 1;
                end else if (!done[l] && rdy_a[l]) begin
                    pend[l] = 1;
                end
            end
            if (!(done[0] && done[1])) begin
                if (t++ == 300) begin
                    fail_now("accept_timeout");
                    for (int l = 0; l < 2; l++) req_valid_a[l] = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_rsp(input int c0, input int c1, input logic [DW-1:0] exp, input string name);
        int t = 0;
        while ((got_cnt_a[0] <= c0 || got_cnt_a[1] <= c1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now(name);
        for (int l = 0; l < 2; l++) chk(name, l, got_a[l], exp);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
        int c0 = got_cnt_a[0];
        int c1 = got_cnt_a[1];
        issue(1'b0, a, '0);
        wait_rsp(c0, c1, exp, name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0, t1;
        int  c0, c1, t;
        int  a0 [2];
        for (int l = 0; l < 2; l++) begin
            req_valid_a[l] = 0; req_wr_a[l] = 0; req_addr_a[l] = '0; req_wdata_a[l] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk("reset_req_ready", l, rdy_a[l], 0);
            chk("reset_rsp_valid", l, rsp_valid_a[l], 0);
            chk("reset_rsp_rdata", l, rdata_a[l], 0);
            chk("reset_strobes", l, {cs_a[l], oe_a[l], we_a[l]}, 0);
            chk("reset_mem_addr", l, addr_a[l], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort a read asynchronously, between edges.
        issue(1'b1, 4'd2, 8'h22);
        repeat (2) @(negedge clk);
        issue(1'b0, 4'd2, '0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("rst_mid_read_cs_oe", l, {cs_a[l], oe_a[l]}, 0);
            chk("rst_mid_read_bus", l, bus_free(data_a[l]), 1);
            chk("rst_mid_read_rsp_valid", l, rsp_valid_a[l], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Abort a write while it drives the bus.
        issue(1'b1, 4'd9, 8'h99);
        #1 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("rst_mid_write_bus", l, bus_free(data_a[l]), 1);
            chk("rst_mid_write_strobes", l, {cs_a[l], we_a[l]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Back-to-back writes with req_valid held high.
        t0 = $time;
        for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), DW'(8'hA0 + i));
        t1 = $time;
`ifdef SPRAM_CTRL_WRACK_EN
        chk("write_rate", 0, 32'((t1 - t0) / 10), 46);
`else
        chk("write_rate", 0, 32'((t1 - t0) / 10), 31);
`endif
        repeat (3) @(negedge clk);

        for (int i = 0; i < 16; i++) read_chk(AW'(i), DW'(8'hA0 + i), "read_sweep");

        // Response held off by the master.
        rsp_mode = 2;
        c0 = got_cnt_a[0];
        c1 = got_cnt_a[1];
        issue(1'b0, 4'd5, '0);
        t = 0;
        while (!(rsp_valid_a[0] && rsp_valid_a[1]) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("held_rsp_valid");
        for (int l = 0; l < 2; l++) begin
            req_valid_a[l] = 1'b1; req_wr_a[l] = 1'b0; req_addr_a[l] = 4'd6;
        end
        repeat (4) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                chk("held_rsp_valid", l, rsp_valid_a[l], 1);
                chk("held_rsp_rdata", l, rdata_a[l], 8'hA5);
                chk("held_req_ready", l, rdy_a[l], 0);
            end
        end
        rsp_mode = 0;
        issue(1'b0, 4'd6, '0);
        wait_rsp(c0, c1, 8'hA5, "held_read");
        wait_rsp(c0 + 1, c1 + 1, 8'hA6, "next_read");

        // Read, then write the same word, then read it back.
        read_chk(4'd3, 8'hA3, "rmw_first_read");
        issue(1'b1, 4'd3, 8'h5C);
        read_chk(4'd3, 8'h5C, "rmw_final_read");

`ifdef SPRAM_CTRL_WRACK_EN
        repeat (3) @(negedge clk);
        a0[0] = ack_cnt_a[0];
        a0[1] = ack_cnt_a[1];
        issue(1'b1, 4'd7, 8'h11);
        repeat (6) @(negedge clk);
        for (int l = 0; l < 2; l++) chk("write_ack_count", l, ack_cnt_a[l] - a0[l], 1);
        read_chk(4'd7, 8'h11, "wrack_readback");
`else
        for (int l = 0; l < 2; l++) a0[l] = 0;
        for (int l = 0; l < 2; l++) chk("no_write_ack", l, ack_cnt_a[l], a0[l]);
`endif

        // Random traffic with a random response back-pressure.
        rsp_mode = 1;
        for (int n = 0; n < 150; n++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rsp_mode = 0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Initiator-side controller for the single-port RAM (SPRAM) interface: cs, oe, wr_en, addr and a shared bidirectional data bus.
- Converts a simple valid/ready request channel into correctly sequenced SPRAM read and write cycles.
- Returns read data on a valid/ready response channel.
- Sits between any master (CPU stub, DMA, test sequencer) and one SPRAM instance, so no master ever drives the tri-state bus directly.

Parameters:
- Data_Width, 8, width of the data bus and of request/response data.
- RAM_Depth, 16, number of words; address width is $clog2(RAM_Depth).
- READ_LATENCY, 1, clock edges between read address presentation (cs=1, oe=1) and valid data on mem_data; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  $clog2(RAM_Depth)  word address.
- req_wdata  in  Data_Width  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  Data_Width  read data.
- mem_cs  out  1  SPRAM chip select.
- mem_oe  out  1  SPRAM output enable.
- mem_wr_en  out  1  SPRAM write enable.
- mem_addr  out  $clog2(RAM_Depth)  SPRAM address.
- mem_data  inout  Data_Width  shared SPRAM data bus; driven only during a write.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=0 while rst_n=0, and 1 from the first edge after release.
  - rsp_valid=0, rsp_rdata=0, mem_cs=0, mem_oe=0, mem_wr_en=0, mem_addr=0.
  - mem_data='bz immediately, not waiting for a clock edge.
- All outputs are registered; mem_data drive-enable is registered as well.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1; all mem_* strobes 0; bus released.
  - On req_valid & req_ready, latch addr, wdata and wr; go to WRITE if req_wr=1, else READ.
- WRITE (exactly 1 cycle):
  - mem_cs=1, mem_wr_en=1, mem_oe=0, mem_addr=latched addr, mem_data=latched wdata.
  - SPRAM samples at the closing edge; next state IDLE.
  - Write throughput: 1 write per 2 cycles.
- READ (READ_LATENCY+1 cycles):
  - mem_cs=1, mem_oe=1, mem_wr_en=0, mem_addr held, bus released.
  - Internal counter runs 0..READ_LATENCY.
  - At the edge closing count=READ_LATENCY, mem_data is captured into rsp_rdata; go to RESP.
- RESP:
  - rsp_valid=1, rsp_rdata stable; all strobes 0; req_ready=0.
  - Held until rsp_ready=1, then IDLE on the next edge.
  - rsp_ready is ignored when rsp_valid=0.
- Bus turnaround: mem_oe is always 0 for at least one cycle (RESP, then IDLE) before any WRITE drives mem_data. The controller and the SPRAM never drive simultaneously.
- One outstanding transaction at a time; requests arriving outside IDLE see req_ready=0 and must be held by the master.
- mem_wr_en and mem_oe are never both 1; mem_cs=0 implies both are 0.
- Address is passed through unmodified; no wrap or range check, since the width fully covers RAM_Depth.
- Reset asserted mid-transaction aborts it:
  - An in-flight write may or may not have landed.
  - No response is generated after reset.
  - Bus is released immediately.

Optional Feature:
- SPRAM_CTRL_WRACK_EN defined:
  - WRITE goes to RESP instead of IDLE.
  - rsp_valid=1 with rsp_rdata=0 acknowledges each write; the master must consume it with rsp_ready.
  - Write throughput becomes at most 1 per 3 cycles.
- Not defined: writes produce no response, as described above.

Test Plan:
- Reset with rst_n=0 mid-READ (async, between edges) -> mem_cs/mem_oe drop and mem_data='bz within the same cycle; rsp_valid stays 0 after release.
- Write addr 0..15 with data 8'hA0+i back-to-back, req_valid held high -> req_ready pulses every 2nd cycle; each WRITE cycle shows mem_cs=1, mem_wr_en=1, mem_oe=0, mem_data=8'hA0+i.
- Read addr 0..15 with rsp_ready=1 -> rsp_rdata=8'hA0+i; rsp_valid exactly READ_LATENCY+2 cycles after acceptance; mem_oe high for READ_LATENCY+1 cycles.
- Read addr 5, then hold rsp_ready=0 for 4 cycles -> rsp_valid stays 1 with rsp_rdata=8'hA5 stable; req_ready=0 throughout; a new request is accepted only after rsp_ready=1.
- Read addr 3 immediately followed by a write of 8'h5C to addr 3, then read addr 3 -> no cycle has the controller driving mem_data while mem_oe=1; the final read returns 8'h5C. Repeat with READ_LATENCY=3.
- With SPRAM_CTRL_WRACK_EN defined: write 8'h11 to addr 7 -> one rsp_valid pulse with rsp_rdata=0; a read of addr 7 then returns 8'h11.
